// File: rtl/request_unit_wd_if.sv
// Bundle of the request unit's handshake, enable and statistics signals.
// Latency: none, wires only.
// Backpressure: dstall carries the hold request back toward the pipeline.
interface request_unit_wd_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_read;
    logic             mem_write;
    logic             halt;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             dstall;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] ireq_cnt;
    logic [CNT_W-1:0] dreq_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Control/hazard side: drives hits and decoded ops, observes enables.
    modport master (
        output ihit, dhit, mem_read, mem_write, halt,
        input  imemREN, dmemREN, dmemWEN, dstall, halted, timeout_err,
        input  ireq_cnt, dreq_cnt, stall_cnt
    );

    // Request unit side.
    modport slave (
        input  ihit, dhit, mem_read, mem_write, halt,
        output imemREN, dmemREN, dmemWEN, dstall, halted, timeout_err,
        output ireq_cnt, dreq_cnt, stall_cnt
    );
endinterface

// File: rtl/request_unit_wd.sv
// Sequences imem/dmem enables with data priority, orderly halt and a data-wait watchdog.
// Latency: enables change the cycle after the qualifying ihit/dhit (registered Moore outputs).
// Backpressure: dstall holds the pipeline while a data access waits; stats need REQUEST_UNIT_STATS_EN.
module request_unit_wd #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 200,
    parameter int CNT_W       = 16
) (
    input logic               CLK,
    input logic               nRST,
    request_unit_wd_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DREQ_R, DREQ_W, HALTED, ERR} state_t;

    localparam bit                   WD_EN     = (TIMEOUT_MAX != 0);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(WD_EN ? TIMEOUT_MAX - 1 : 0);

    state_t               state;
    state_t               state_nxt;
    logic                 halt_pend;
    logic                 halt_pend_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 in_dreq;
    logic                 wait_last;
    logic                 imem_ren;
    logic                 dmem_ren;
    logic                 dmem_wen;
    logic                 dstall_q;
    logic                 halted_q;
    logic                 err_q;

    assign in_dreq = (state == DREQ_R) || (state == DREQ_W);
    // With the watchdog off the wait counter simply saturates at all-ones.
    assign wait_last = WD_EN ? (wait_cnt == WAIT_LAST) : (wait_cnt == '1);

    // Next-state and pending-halt decision; dhit beats a simultaneous timeout.
    always_comb begin
        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        case (state)
            IDLE: begin
                if (bus.ihit) begin
                    if (bus.mem_write) begin
                        state_nxt     = DREQ_W;
                        halt_pend_nxt = bus.halt;
                    end else if (bus.mem_read) begin
                        state_nxt     = DREQ_R;
                        halt_pend_nxt = bus.halt;
                    end else if (bus.halt) begin
                        state_nxt = HALTED;
                    end
                end
            end
            DREQ_R, DREQ_W: begin
                if (bus.dhit) begin
                    state_nxt     = halt_pend ? HALTED : IDLE;
                    halt_pend_nxt = 1'b0;
                end else if (WD_EN && wait_last) begin
                    state_nxt = ERR;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // State, wait counter and registered Moore outputs decoded from the next state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            halt_pend <= 1'b0;
            wait_cnt  <= '0;
            imem_ren  <= 1'b1;
            dmem_ren  <= 1'b0;
            dmem_wen  <= 1'b0;
            dstall_q  <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            halt_pend <= halt_pend_nxt;
            imem_ren  <= (state_nxt == IDLE);
            dmem_ren  <= (state_nxt == DREQ_R);
            dmem_wen  <= (state_nxt == DREQ_W);
            dstall_q  <= (state_nxt == DREQ_R) || (state_nxt == DREQ_W);
            halted_q  <= (state_nxt == HALTED);
            err_q     <= (state_nxt == ERR);
            // Requests are only entered from IDLE, so clearing here clears on entry.
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (in_dreq && !bus.dhit && !wait_last) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus.imemREN     = imem_ren;
    assign bus.dmemREN     = dmem_ren;
    assign bus.dmemWEN     = dmem_wen;
    assign bus.dstall      = dstall_q;
    assign bus.halted      = halted_q;
    assign bus.timeout_err = err_q;

`ifdef REQUEST_UNIT_STATS_EN
    logic [CNT_W-1:0] ireq_q;
    logic [CNT_W-1:0] dreq_q;
    logic [CNT_W-1:0] stall_q;

    // Saturating statistics; HALTED and ERR never match so counters freeze there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ireq_q  <= '0;
            dreq_q  <= '0;
            stall_q <= '0;
        end else begin
            if ((state == IDLE) && bus.ihit && (ireq_q != '1)) begin
                ireq_q <= ireq_q + 1'b1;
            end
            if (in_dreq && bus.dhit && (dreq_q != '1)) begin
                dreq_q <= dreq_q + 1'b1;
            end
            if (in_dreq && !bus.dhit && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.ireq_cnt  = ireq_q;
    assign bus.dreq_cnt  = dreq_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.ireq_cnt  = {CNT_W{1'b0}};
    assign bus.dreq_cnt  = {CNT_W{1'b0}};
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_request_unit_wd.sv
// Self-checking bench for request_unit_wd with TIMEOUT_MAX=4 and 2-bit counters.
// Latency: each vector is checked one cycle after it is driven.
// Backpressure: dhit patterns in the table exercise stalls and the watchdog.
module tb_request_unit_wd;
    localparam int CNT_W = 2;
`ifdef REQUEST_UNIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Output flag order: {imemREN, dmemREN, dmemWEN, dstall, halted, timeout_err}
    localparam logic [5:0] F_I = 6'b100000;
    localparam logic [5:0] F_R = 6'b010100;
    localparam logic [5:0] F_W = 6'b001100;
    localparam logic [5:0] F_H = 6'b000010;
    localparam logic [5:0] F_E = 6'b000001;

    typedef struct {
        logic             rst_n;
        logic             ihit;
        logic             dhit;
        logic             rd;
        logic             wr;
        logic             hlt;
        logic [5:0]       flags;
        logic [CNT_W-1:0] ic;
        logic [CNT_W-1:0] dc;
        logic [CNT_W-1:0] sc;
    } vec_t;

    typedef struct {
        int               idx;
        logic [5:0]       flags;
        logic [CNT_W-1:0] ic;
        logic [CNT_W-1:0] dc;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic CLK;
    logic nRST;
    int   total;
    int   bad;
    int   vec_no;
    vec_t tbl[$];
    exp_t sb[$];

    request_unit_wd_if #(.CNT_W(CNT_W)) bus ();

    request_unit_wd #(
        .TIMEOUT_W  (3),
        .TIMEOUT_MAX(4),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input bit r, input bit i, input bit d, input bit rd,
                                input bit wr, input bit h, input logic [5:0] f,
                                input int ic, input int dc, input int sc);
        vec_t v;
        v.rst_n = r;
        v.ihit  = i;
        v.dhit  = d;
        v.rd    = rd;
        v.wr    = wr;
        v.hlt   = h;
        v.flags = f;
        v.ic    = STATS ? CNT_W'(ic) : '0;
        v.dc    = STATS ? CNT_W'(dc) : '0;
        v.sc    = STATS ? CNT_W'(sc) : '0;
        return v;
    endfunction

    function automatic logic [5:0] flags_now();
        return {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.dstall, bus.halted, bus.timeout_err};
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, want);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = sb.pop_front();
            chk("flags", e.idx, {2'b00, flags_now()}, {2'b00, e.flags});
            chk("ireq_cnt", e.idx, 8'(bus.ireq_cnt), 8'(e.ic));
            chk("dreq_cnt", e.idx, 8'(bus.dreq_cnt), 8'(e.dc));
            chk("stall_cnt", e.idx, 8'(bus.stall_cnt), 8'(e.sc));
        end
    endtask

    // Drive one vector mid-cycle, record its expectation, check after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge CLK);
        nRST          = v.rst_n;
        bus.ihit      = v.ihit;
        bus.dhit      = v.dhit;
        bus.mem_read  = v.rd;
        bus.mem_write = v.wr;
        bus.halt      = v.hlt;
        e.idx   = vec_no;
        e.flags = v.flags;
        e.ic    = v.ic;
        e.dc    = v.dc;
        e.sc    = v.sc;
        sb.push_back(e);
        vec_no++;
        @(posedge CLK);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        total  = 0;
        bad    = 0;
        vec_no = 0;
        nRST          = 1'b0;
        bus.ihit      = 1'b0;
        bus.dhit      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.halt      = 1'b0;

        //                 r  i  d  rd wr h  flags ic dc sc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, F_I, 0, 0, 0)); // reset values
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_I, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, F_R, 1, 0, 0)); // load
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 2));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, F_I, 1, 1, 2)); // dhit on 3rd cycle
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, F_W, 2, 1, 2)); // write wins over read
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, F_I, 2, 2, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, F_I, 3, 2, 2)); // dhit ignored in IDLE
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, F_I, 3, 2, 2)); // ireq saturates
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, F_I, 3, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, F_I, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, F_W, 1, 0, 0)); // store + halt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_W, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, F_H, 1, 1, 1)); // halt after access
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, F_H, 1, 1, 1)); // frozen in HALTED
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, F_H, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, F_I, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, F_R, 1, 0, 0)); // load, no dhit
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_E, 1, 0, 3)); // watchdog fires
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, F_E, 1, 0, 3)); // ERR absorbing
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, F_I, 0, 0, 0)); // reset clears ERR
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_I, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, F_R, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, F_I, 1, 1, 3)); // dhit beats timeout
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, F_I, 1, 1, 3)); // no ihit: ignored
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, F_H, 2, 1, 3)); // plain halt

        foreach (tbl[k]) begin
            step(tbl[k]);
        end

        // Asynchronous reset out of HALTED, observed before any clock edge.
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("async_rst_halted", vec_no, {2'b00, flags_now()}, {2'b00, F_I});

        // Reset mid-request aborts the store with no completion counted.
        step(mk(1, 1, 0, 0, 1, 0, F_W, 1, 0, 0));
        @(negedge CLK);
        bus.ihit = 1'b0;
        bus.mem_write = 1'b0;
        bus.dhit = 1'b1;
        nRST = 1'b0;
        #1;
        chk("async_rst_req", vec_no, {2'b00, flags_now()}, {2'b00, F_I});
        chk("async_rst_dreq", vec_no, 8'(bus.dreq_cnt), 8'd0);
        step(mk(1, 0, 1, 0, 0, 0, F_I, 0, 0, 0));

        // Drive into ERR again, then random inputs must not move it.
        step(mk(1, 1, 0, 1, 0, 0, F_R, 1, 0, 0));
        for (int n = 1; n <= 3; n++) begin
            step(mk(1, 0, 0, 0, 0, 0, F_R, 1, 0, n));
        end
        step(mk(1, 0, 0, 0, 0, 0, F_E, 1, 0, 3));
        for (int n = 0; n < 8; n++) begin
            step(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    F_E, 1, 0, 3));
        end

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
